// File: rtl/sfx_scheduler_pkg.sv
// sfx_scheduler_pkg: sound ids, scheduler states and priority helpers shared by the sfx scheduler.
package sfx_pkg;
  localparam logic [1:0] SFX_NONE   = 2'd0;
  localparam logic [1:0] SFX_WALL   = 2'd1;
  localparam logic [1:0] SFX_PADDLE = 2'd2;
  localparam logic [1:0] SFX_SCORE  = 2'd3;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  function automatic logic [1:0] prio_rank(input logic [1:0] id);
    return id == SFX_SCORE ? 2'd3 : id == SFX_PADDLE ? 2'd2 : id == SFX_WALL ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] top_id(input logic [2:0] m);
    return m[2] ? SFX_SCORE : m[1] ? SFX_PADDLE : m[0] ? SFX_WALL : SFX_NONE;
  endfunction

  function automatic logic [2:0] id_mask(input logic [1:0] id);
    return id == SFX_SCORE ? 3'b100 : id == SFX_PADDLE ? 3'b010 : id == SFX_WALL ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/sfx_scheduler_if.sv
// sfx_scheduler_if: event requests in, active sound id / beat index / pulses out.
interface sfx_scheduler_if;
  logic       en;
  logic [2:0] req;
  logic       busy;
  logic [1:0] sound_id;
  logic [7:0] ibeat;
  logic       beat_tick;
  logic       done;
  modport master (output en, req, input busy, sound_id, ibeat, beat_tick, done);
  modport slave  (input en, req, output busy, sound_id, ibeat, beat_tick, done);
endinterface

// File: rtl/sfx_beat_divider.sv
// sfx_beat_divider: counts clk cycles while run, ticks on the last cycle of each beat.
module sfx_beat_divider #(
  parameter int BEAT_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);
  localparam int W = $clog2(BEAT_DIV);
  logic [W-1:0] cnt;
  assign tick = run && cnt == W'(BEAT_DIV - 1);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority arbiter and beat FSM sharing one sfx sequencer among three events.
module sfx_scheduler
  import sfx_pkg::*;
#(
  parameter int BEAT_DIV   = 12500000,
  parameter int LEN_WALL   = 6,
  parameter int LEN_PADDLE = 7,
  parameter int LEN_SCORE  = 15
) (
  input logic           clk,
  input logic           reset,
  sfx_scheduler_if.slave bus
);
  state_t     st;
  logic [1:0] sid;
  logic [7:0] ib;
  logic       bsy;
  logic [2:0] pend;
  logic       tick, run, clear, last, preempt;
  logic [1:0] req_id, any_id, grant_id;
  logic [2:0] pend_next;

  function automatic logic [7:0] len_of(input logic [1:0] id);
    return id == SFX_SCORE ? 8'(LEN_SCORE) : id == SFX_PADDLE ? 8'(LEN_PADDLE) : 8'(LEN_WALL);
  endfunction

  sfx_beat_divider #(.BEAT_DIV(BEAT_DIV)) u_div (
    .clk(clk), .reset(reset), .clear(clear), .run(run), .tick(tick)
  );

  // same-cycle requests count as pending, so a GAP-end grant already sees them
  always_comb begin
    req_id    = top_id(bus.req);
    any_id    = top_id(bus.req | pend);
    last      = ib == len_of(sid) - 8'd1;
    preempt   = bus.en && st == PLAY && req_id != SFX_NONE && prio_rank(req_id) >= prio_rank(sid);
    grant_id  = preempt ? req_id : (st == IDLE || (st == GAP && tick)) ? any_id : SFX_NONE;
    pend_next = (pend | bus.req) & ~id_mask(grant_id);
    run       = bus.en && st != IDLE;
    clear     = !bus.en || grant_id != SFX_NONE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset || !bus.en) begin
      st   <= IDLE;
      sid  <= SFX_NONE;
      ib   <= '0;
      bsy  <= 1'b0;
      pend <= '0;
    end else begin
      pend <= pend_next;
      if (grant_id != SFX_NONE) begin
        st  <= PLAY;
        sid <= grant_id;
        ib  <= '0;
        bsy <= 1'b1;
      end else if (st == PLAY && tick) begin
        if (last) begin
          st  <= GAP;
          sid <= SFX_NONE;
          ib  <= '0;
        end else ib <= ib + 8'd1;
      end else if (st == GAP && tick) begin
        st  <= IDLE;
        bsy <= 1'b0;
      end
    end

  assign bus.busy      = bsy;
  assign bus.sound_id  = sid;
  assign bus.ibeat     = ib;
  assign bus.beat_tick = tick;
  assign bus.done      = tick && st == PLAY && last && !preempt;
endmodule

// File: tb/tb_sfx_scheduler.sv
// tb_sfx_scheduler: directed scenarios plus random traffic checked against a beat-level reference model.
module tb_sfx_scheduler;
  localparam int BD = 4, LW = 6, LP = 7, LS = 15;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0, ndone = 0;
  int m_mode, m_id, m_beat, m_div;
  bit [2:0] m_pend;

  sfx_scheduler_if bus();
  sfx_scheduler #(.BEAT_DIV(BD), .LEN_WALL(LW), .LEN_PADDLE(LP), .LEN_SCORE(LS)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int len_of(int id);
    return id == 3 ? LS : id == 2 ? LP : LW;
  endfunction

  function automatic int top_of(bit [2:0] m);
    for (int b = 2; b >= 0; b--) if (m[b]) return b + 1;
    return 0;
  endfunction

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_mode = 0; m_id = 0; m_beat = 0; m_div = 0; m_pend = 3'b000;
  endtask

  // mode: 0 idle, 1 playing m_id, 2 silent gap; m_div is the cycle position inside the beat
  task automatic cycle(bit en, bit [2:0] req);
    int hr, g;
    bit bnd, pre, dn;
    bit [2:0] np;
    bus.en = en;
    bus.req = req;
    @(negedge clk);
    hr  = top_of(req);
    bnd = en && m_mode != 0 && m_div == BD - 1;
    pre = en && m_mode == 1 && hr > 0 && hr >= m_id;
    dn  = bnd && m_mode == 1 && m_beat == len_of(m_id) - 1 && !pre;
    chk("busy", int'(bus.busy), int'(m_mode != 0));
    chk("sound_id", int'(bus.sound_id), m_mode == 1 ? m_id : 0);
    chk("ibeat", int'(bus.ibeat), m_mode == 1 ? m_beat : 0);
    chk("beat_tick", int'(bus.beat_tick), int'(bnd));
    chk("done", int'(bus.done), int'(dn));
    if (bus.done) ndone++;
    @(posedge clk);
    if (!en) m_clear();
    else begin
      np = m_pend | req;
      g = pre ? hr : (m_mode == 0 || (m_mode == 2 && bnd)) ? top_of(np) : 0;
      if (g != 0) begin
        np[g-1] = 1'b0;
        m_mode = 1; m_id = g; m_beat = 0; m_div = 0;
      end else if (m_mode != 0) begin
        m_div = bnd ? 0 : m_div + 1;
        if (bnd && m_mode == 2) m_mode = 0;
        else if (bnd && m_beat == len_of(m_id) - 1) begin
          m_mode = 2; m_beat = 0;
        end else if (bnd) m_beat++;
      end
      m_pend = np;
    end
    #1;
  endtask

  task automatic idle_cycles(int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 3'b000);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.req = 3'b000;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sound_id", int'(bus.sound_id), 0);
    chk("rst_ibeat", int'(bus.ibeat), 0);
    chk("rst_done", int'(bus.done), 0);
    reset = 1'b0;

    ndone = 0;
    cycle(1'b1, 3'b001);
    chk("t1_sid", int'(bus.sound_id), 1);
    idle_cycles(40);
    chk("t1_done_cnt", ndone, 1);
    chk("t1_idle", int'(bus.busy), 0);

    cycle(1'b1, 3'b001);
    idle_cycles(9);
    chk("t2_wall_beat2", int'(bus.ibeat), 2);
    cycle(1'b1, 3'b100);
    chk("t2_preempt_sid", int'(bus.sound_id), 3);
    idle_cycles(80);

    cycle(1'b1, 3'b010);
    idle_cycles(5);
    cycle(1'b1, 3'b001);
    chk("t3_keep_paddle", int'(bus.sound_id), 2);
    idle_cycles(100);

    ndone = 0;
    cycle(1'b1, 3'b111);
    idle_cycles(150);
    chk("t4_done_cnt", ndone, 3);

    cycle(1'b1, 3'b010);
    idle_cycles(17);
    chk("t5_paddle_beat4", int'(bus.ibeat), 4);
    cycle(1'b1, 3'b010);
    chk("t5_restart", int'(bus.ibeat), 0);
    idle_cycles(40);

    cycle(1'b1, 3'b100);
    idle_cycles(3);
    cycle(1'b1, 3'b001);
    idle_cycles(3);
    cycle(1'b0, 3'b000);
    chk("t6_en0_busy", int'(bus.busy), 0);
    chk("t6_en0_sid", int'(bus.sound_id), 0);
    idle_cycles(12);
    chk("t6_no_resume", int'(bus.busy), 0);
    cycle(1'b1, 3'b010);
    idle_cycles(5);
    reset = 1'b1;
    #2;
    chk("t6_arst_busy", int'(bus.busy), 0);
    chk("t6_arst_sid", int'(bus.sound_id), 0);
    chk("t6_arst_ibeat", int'(bus.ibeat), 0);
    m_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      bit [2:0] r;
      for (int b = 0; b < 3; b++) r[b] = ($urandom_range(0, 9) == 0);
      cycle($urandom_range(0, 63) != 0, r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
